packet_generator_replay_ctrl: RTL and testbench

PACKET_GENERATOR_REPLAY_CTRL -- requirements
Module: packet_generator_replay_ctrl

---
 rtl/packet_generator_replay_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_packet_generator_replay_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_generator_replay_ctrl.sv
// Frame serializer with a sliding ID window and go-back-N replay from an external buffer.
// New frames are streamed from a local latch; replayed frames are streamed from i_buf_byte.
module packet_generator_replay_ctrl #(
  parameter int unsigned FRAME_WIDTH = 56,
  parameter int unsigned ID_WIDTH    = 3
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  input  logic                   i_frame_valid,
  input  logic [FRAME_WIDTH-1:0] i_frame,
  output logic                   o_frame_ready,
  input  logic                   i_ack_valid,
  input  logic                   i_ack_nack,
  input  logic [ID_WIDTH-1:0]    i_ack_id,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic [7:0]             o_tx_byte,
  output logic                   o_tx_sof,
  output logic                   o_tx_retry,
  output logic [ID_WIDTH-1:0]    o_tx_id,
  output logic                   o_buf_set_id,
  output logic                   o_buf_wr,
  output logic                   o_buf_rd,
  output logic [ID_WIDTH-1:0]    o_buf_id,
  output logic [7:0]             o_buf_byte,
  input  logic [7:0]             i_buf_byte,
  output logic [ID_WIDTH-1:0]    o_outstanding,
  output logic                   o_replay_active
);

  localparam int unsigned FrameBytes = (FRAME_WIDTH + 7) / 8;
  localparam int unsigned PadBits    = FrameBytes * 8;
  localparam int unsigned CntWidth   = (FrameBytes > 1) ? $clog2(FrameBytes) : 1;
  localparam logic [CntWidth-1:0] LastByte = CntWidth'(FrameBytes - 1);
  localparam logic [ID_WIDTH-1:0] WinMax   = '1;

  typedef enum logic [2:0] {
    StIdle,
    StNewSetid,
    StNewSend,
    StRplSetid,
    StRplSend
  } state_e;

  state_e                 state_q, state_d;
  logic [ID_WIDTH-1:0]    next_id_q, next_id_d;
  logic [ID_WIDTH-1:0]    oldest_id_q, oldest_id_d;
  logic [ID_WIDTH-1:0]    count_q, count_d;
  logic [ID_WIDTH-1:0]    rpl_id_q, rpl_id_d;
  logic                   rpl_pend_q, rpl_pend_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic [FRAME_WIDTH-1:0] frame_q, frame_d;

  logic [ID_WIDTH-1:0] ack_dist;
  logic                ack_in_win, ack_now, nack_now;
  logic                accept_ok;
  logic [PadBits-1:0]  frame_pad, frame_sel;
  logic [7:0]          new_byte;
  logic [ID_WIDTH-1:0] count_inc, count_dec, rpl_dist;
  logic                rpl_done;

  // Window membership is a modular distance from the oldest unacknowledged ID.
  assign ack_dist   = i_ack_id - oldest_id_q;
  assign ack_in_win = i_ack_valid && (ack_dist < count_q);
  assign ack_now    = ack_in_win && !i_ack_nack;
  assign nack_now   = ack_in_win && i_ack_nack;

  assign accept_ok     = i_arst_n && (state_q == StIdle) && !rpl_pend_q && (count_q < WinMax);
  assign o_frame_ready = accept_ok;
  assign o_outstanding = count_q;

  // Left-align the payload so short frames pad with zeros at the tail.
  assign frame_pad = PadBits'(frame_q) << (PadBits - FRAME_WIDTH);

  always_comb begin
    frame_sel = frame_pad << {cnt_q, 3'b000};
    new_byte  = frame_sel[PadBits-1 -: 8];
  end

  always_comb begin
    state_d     = state_q;
    next_id_d   = next_id_q;
    oldest_id_d = oldest_id_q;
    count_d     = count_q;
    rpl_id_d    = rpl_id_q;
    rpl_pend_d  = rpl_pend_q;
    cnt_d       = cnt_q;
    frame_d     = frame_q;
    count_inc   = '0;
    count_dec   = '0;
    rpl_dist    = '0;
    rpl_done    = 1'b0;

    o_tx_valid      = 1'b0;
    o_tx_byte       = '0;
    o_tx_sof        = 1'b0;
    o_tx_retry      = 1'b0;
    o_tx_id         = '0;
    o_buf_set_id    = 1'b0;
    o_buf_wr        = 1'b0;
    o_buf_rd        = 1'b0;
    o_buf_id        = '0;
    o_buf_byte      = '0;
    o_replay_active = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_frame_valid && accept_ok) begin
          frame_d = i_frame;
          state_d = StNewSetid;
        end else if (rpl_pend_q || nack_now) begin
          state_d = StRplSetid;
        end
      end
      StNewSetid: begin
        o_buf_set_id = 1'b1;
        o_buf_id     = next_id_q;
        cnt_d        = '0;
        state_d      = StNewSend;
      end
      StNewSend: begin
        o_tx_valid = 1'b1;
        o_tx_byte  = new_byte;
        o_tx_sof   = (cnt_q == '0);
        o_tx_id    = next_id_q;
        o_buf_id   = next_id_q;
        o_buf_byte = new_byte;
        o_buf_wr   = i_tx_ready;
        if (i_tx_ready) begin
          if (cnt_q == LastByte) begin
            cnt_d     = '0;
            next_id_d = next_id_q + 1'b1;
            count_inc = ID_WIDTH'(1);
            state_d   = (rpl_pend_q || nack_now) ? StRplSetid : StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StRplSetid: begin
        o_buf_set_id    = 1'b1;
        o_buf_id        = rpl_id_q;
        o_replay_active = 1'b1;
        cnt_d           = '0;
        // A NACK here re-points the buffer before any replay byte is read.
        state_d         = nack_now ? StRplSetid : StRplSend;
      end
      StRplSend: begin
        o_tx_valid      = 1'b1;
        o_tx_byte       = i_buf_byte;
        o_tx_sof        = (cnt_q == '0);
        o_tx_retry      = 1'b1;
        o_tx_id         = rpl_id_q;
        o_buf_id        = rpl_id_q;
        o_buf_rd        = i_tx_ready;
        o_replay_active = 1'b1;
        if (i_tx_ready) begin
          if (cnt_q == LastByte) begin
            cnt_d    = '0;
            rpl_done = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (ack_now) begin
      oldest_id_d = i_ack_id + 1'b1;
      count_dec   = ack_dist + 1'b1;
    end else if (nack_now) begin
      oldest_id_d = i_ack_id;
      count_dec   = ack_dist;
      rpl_id_d    = i_ack_id;
      rpl_pend_d  = 1'b1;
    end
    count_d = count_q + count_inc - count_dec;

    // A pending NACK already holds the restart ID in rpl_id, so skip the advance.
    if (rpl_done) begin
      if (rpl_pend_q || nack_now) begin
        state_d = StRplSetid;
      end else begin
        rpl_id_d = rpl_id_q + 1'b1;
        rpl_dist = rpl_id_d - oldest_id_d;
        if ((rpl_id_d == next_id_q) || (rpl_dist >= count_d)) begin
          state_d = StIdle;
        end else begin
          state_d = StRplSetid;
        end
      end
    end

    if (state_d == StRplSetid) begin
      rpl_pend_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q     <= StIdle;
      next_id_q   <= '0;
      oldest_id_q <= '0;
      count_q     <= '0;
      rpl_id_q    <= '0;
      rpl_pend_q  <= 1'b0;
      cnt_q       <= '0;
      frame_q     <= '0;
    end else begin
      state_q     <= state_d;
      next_id_q   <= next_id_d;
      oldest_id_q <= oldest_id_d;
      count_q     <= count_d;
      rpl_id_q    <= rpl_id_d;
      rpl_pend_q  <= rpl_pend_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
    end
  end

endmodule

// File: tb/tb_packet_generator_replay_ctrl.sv
// Bench for packet_generator_replay_ctrl: queue-based window/scoreboard model plus a behavioural
// replay buffer, with directed scenarios and literal expectations.
module tb_packet_generator_replay_ctrl;

  localparam int unsigned FW = 56;
  localparam int unsigned IW = 3;
  localparam int unsigned N  = 1 << IW;
  localparam int unsigned FB = (FW + 7) / 8;

  logic          clk = 1'b0;
  logic          arst_n = 1'b1;
  logic          frame_valid, frame_ready;
  logic [FW-1:0] frame;
  logic          ack_valid, ack_nack;
  logic [IW-1:0] ack_id;
  logic          tx_valid, tx_ready, tx_sof, tx_retry;
  logic [7:0]    tx_byte;
  logic [IW-1:0] tx_id, buf_id, outstanding;
  logic          buf_set_id, buf_wr, buf_rd, replay_active;
  logic [7:0]    buf_byte_o, buf_rdata;
  logic          toggle;

  packet_generator_replay_ctrl #(.FRAME_WIDTH(FW), .ID_WIDTH(IW)) dut (
    .i_clk(clk), .i_arst_n(arst_n),
    .i_frame_valid(frame_valid), .i_frame(frame), .o_frame_ready(frame_ready),
    .i_ack_valid(ack_valid), .i_ack_nack(ack_nack), .i_ack_id(ack_id),
    .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_tx_byte(tx_byte), .o_tx_sof(tx_sof),
    .o_tx_retry(tx_retry), .o_tx_id(tx_id),
    .o_buf_set_id(buf_set_id), .o_buf_wr(buf_wr), .o_buf_rd(buf_rd), .o_buf_id(buf_id),
    .o_buf_byte(buf_byte_o), .i_buf_byte(buf_rdata),
    .o_outstanding(outstanding), .o_replay_active(replay_active)
  );

  initial forever #5 clk = ~clk;

  // Replay buffer: per-ID slot of FB bytes with an auto-incrementing pointer.
  logic [7:0]  mem [0:N*FB];
  int unsigned baddr;
  assign buf_rdata = mem[baddr];
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) baddr <= 0;
    else if (buf_set_id) baddr <= buf_id * FB;
    else if (buf_wr) begin
      mem[baddr] <= buf_byte_o;
      baddr      <= baddr + 1;
    end else if (buf_rd) baddr <= baddr + 1;
  end

  typedef struct {
    logic [7:0]    b;
    logic          sof;
    logic          retry;
    logic [IW-1:0] id;
    logic          last;
  } exp_t;

  exp_t          expq[$];
  logic [IW-1:0] win[$];
  logic [FW-1:0] payload [N];
  logic [IW-1:0] m_next_id;
  int            checks = 0, errors = 0;
  int            wr_pulses = 0, retry_bytes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [FW-1:0] p, input int k);
    logic [FB*8-1:0] ext;
    ext = (FB*8)'(p) << (FB*8 - FW);
    return 8'(ext >> (8 * (FB - 1 - k)));
  endfunction

  task automatic push_frame(input logic [IW-1:0] id, input logic retry);
    exp_t x;
    for (int k = 0; k < int'(FB); k++) begin
      x.b = byte_of(payload[id], k); x.sof = (k == 0); x.retry = retry;
      x.id = id; x.last = (k == int'(FB) - 1);
      expq.push_back(x);
    end
  endtask

  // Model + compare process, sampled on the falling edge.
  exp_t          e;
  int            pos, drop;
  logic [IW-1:0] r;
  initial forever begin
    @(negedge clk);
    if (!arst_n) begin
      chk("reset_outputs", {frame_ready, tx_valid, tx_byte, tx_sof, tx_retry, tx_id, buf_set_id,
                            buf_wr, buf_rd, buf_id, buf_byte_o, outstanding, replay_active}, 0);
      expq.delete(); win.delete(); m_next_id = '0;
    end else begin
      chk("outstanding", outstanding, win.size());
      if (ack_valid) begin
        pos = -1;
        for (int i = 0; i < win.size(); i++) if (win[i] == ack_id) pos = i;
        if (pos >= 0) begin
          drop = ack_nack ? pos : pos + 1;
          repeat (drop) void'(win.pop_front());
          if (ack_nack) begin
            r = ack_id;
            while (r != m_next_id) begin push_frame(r, 1'b1); r = r + 1'b1; end
          end
        end
      end
      if (frame_valid && frame_ready) begin
        payload[m_next_id] = frame;
        push_frame(m_next_id, 1'b0);
        m_next_id = m_next_id + 1'b1;
      end
      if (tx_valid) begin
        if (expq.size() == 0) chk("unexpected_tx", tx_valid, 0);
        else begin
          e = expq[0];
          chk("tx_byte", tx_byte, e.b);
          chk("tx_sof", tx_sof, e.sof);
          chk("tx_retry", tx_retry, e.retry);
          chk("tx_id", tx_id, e.id);
          chk("replay_active", replay_active, e.retry);
          chk("buf_wr", buf_wr, tx_ready && !e.retry);
          chk("buf_rd", buf_rd, tx_ready && e.retry);
          if (buf_wr) chk("buf_byte", buf_byte_o, e.b);
          if (tx_ready) begin
            void'(expq.pop_front());
            if (e.last && !e.retry) win.push_back(e.id);
          end
        end
      end else begin
        chk("idle_buf_strobes", {buf_wr, buf_rd}, 0);
      end
      if (buf_wr) wr_pulses++;
      if (tx_valid && tx_ready && tx_retry) retry_bytes++;
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready = toggle ? ~tx_ready : 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    arst_n = 1'b0; frame_valid = 1'b0; ack_valid = 1'b0;
    cyc(); cyc();
    arst_n = 1'b1;
    cyc();
  endtask

  task automatic send_frame(input logic [FW-1:0] p);
    logic done;
    done = 1'b0;
    frame_valid = 1'b1; frame = p;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = frame_ready;
      cyc();
    end
    frame_valid = 1'b0;
    chk("frame_accept", done, 1);
  endtask

  task automatic send_ack(input logic nack, input logic [IW-1:0] id);
    ack_valid = 1'b1; ack_nack = nack; ack_id = id;
    cyc();
    ack_valid = 1'b0; ack_nack = 1'b0;
  endtask

  task automatic wait_idle();
    int quiet, n;
    quiet = 0; n = 0;
    while (quiet < 3 && n < 400) begin
      @(negedge clk); n++;
      if (!tx_valid && !replay_active && !buf_set_id && expq.size() == 0) quiet++;
      else quiet = 0;
    end
    chk("drain", quiet >= 3, 1);
    cyc();
  endtask

  function automatic logic [FW-1:0] rnd();
    return FW'({$urandom, $urandom});
  endfunction

  int w0, r0;
  initial begin
    toggle = 1'b0; frame_valid = 1'b0; frame = '0;
    ack_valid = 1'b0; ack_nack = 1'b0; ack_id = '0;
    #1 arst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", frame_ready, 0);
    chk("rst_outstanding", outstanding, 0);
    arst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", frame_ready, 1);
    cyc();

    // Single frame timing and byte order.
    w0 = wr_pulses;
    send_frame(56'h01020304050607);
    @(negedge clk);
    chk("t1_setid", buf_set_id, 1);
    chk("t1_setid_id", buf_id, 0);
    chk("t1_no_valid_yet", tx_valid, 0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("t1_valid", tx_valid, 1);
      chk("t1_byte", tx_byte, k + 1);
      chk("t1_sof", tx_sof, k == 0);
    end
    @(negedge clk);
    chk("t1_done_valid", tx_valid, 0);
    chk("t1_outstanding", outstanding, 1);
    chk("t1_buf_wr_count", wr_pulses - w0, 7);
    cyc();

    // Window fills at N-1, cumulative ACK empties it.
    do_reset();
    for (int i = 0; i < 7; i++) send_frame(rnd());
    wait_idle();
    @(negedge clk);
    chk("t2_full_ready", frame_ready, 0);
    chk("t2_full_count", outstanding, 7);
    cyc();
    send_ack(1'b0, 3'd6);
    @(negedge clk);
    chk("t2_acked_count", outstanding, 0);
    chk("t2_acked_ready", frame_ready, 1);
    cyc();

    // NACK from idle replays 1..3.
    do_reset();
    for (int i = 0; i < 4; i++) send_frame(rnd());
    wait_idle();
    r0 = retry_bytes;
    send_ack(1'b1, 3'd1);
    wait_idle();
    @(negedge clk);
    chk("t3_outstanding", outstanding, 3);
    chk("t3_retry_bytes", retry_bytes - r0, 21);
    chk("t3_ready", frame_ready, 1);
    cyc();

    // NACK during byte 3 of frame 3: frame completes, then 2,3 replay.
    do_reset();
    for (int i = 0; i < 3; i++) send_frame(rnd());
    wait_idle();
    r0 = retry_bytes;
    send_frame(rnd());
    repeat (4) cyc();
    send_ack(1'b1, 3'd2);
    wait_idle();
    @(negedge clk);
    chk("t4_outstanding", outstanding, 2);
    chk("t4_retry_bytes", retry_bytes - r0, 14);
    cyc();

    // ACK on the same cycle as the last byte of a new frame.
    do_reset();
    send_frame(rnd());
    wait_idle();
    send_frame(rnd());
    repeat (7) cyc();
    send_ack(1'b0, 3'd0);
    wait_idle();
    @(negedge clk);
    chk("t5_net_count", outstanding, 1);
    cyc();

    // Back-pressure: bytes held, exactly FB writes.
    do_reset();
    toggle = 1'b1;
    w0 = wr_pulses;
    send_frame(rnd());
    wait_idle();
    toggle = 1'b0;
    chk("t6_buf_wr_count", wr_pulses - w0, FB);
    cyc();

    // Out-of-window ACK ignored; reset mid-replay clears outputs at once.
    do_reset();
    for (int i = 0; i < 3; i++) send_frame(rnd());
    wait_idle();
    send_ack(1'b0, 3'd5);
    @(negedge clk);
    chk("t7_ack_ignored", outstanding, 3);
    cyc();
    send_ack(1'b1, 3'd0);
    for (int i = 0; i < 20 && !(tx_valid && tx_retry); i++) cyc();
    chk("t7_in_replay", replay_active, 1);
    cyc(); cyc();
    arst_n = 1'b0;
    #1;
    chk("t7_rst_outputs", {frame_ready, tx_valid, tx_byte, tx_sof, tx_retry, tx_id, buf_set_id,
                           buf_wr, buf_rd, buf_id, buf_byte_o, outstanding, replay_active}, 0);
    cyc();
    arst_n = 1'b1;
    @(negedge clk);
    chk("t7_ready_after", frame_ready, 1);
    chk("t7_count_after", outstanding, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: bench did not complete within time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
